lcd_bus_sequencer: RTL

- Owns the HD44780-style LCD write bus (RS/RW/E/DATA).
- Two requesters share it: the initializer on port 0 and the display refresh driver on port 1.
- Each accepted byte becomes one timed write cycle (setup, enable pulse, hold), followed by a command-dependent execution wait.
- Replaces the ad-hoc mux between initializer and driver outputs in the LCD top level.

---
 rtl/lcd_bus_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/lcd_bus_sequencer.sv
// Two-port arbiter and write-cycle sequencer for an HD44780-style LCD bus.
// Port 0 has fixed priority; each accepted byte gets setup, E pulse, hold and an execution wait.
module lcd_bus_sequencer #(
  parameter int SETUP_CYC     = 3,
  parameter int E_HIGH_CYC    = 25,
  parameter int HOLD_CYC      = 3,
  parameter int EXEC_CYC      = 2500,
  parameter int LONG_EXEC_CYC = 82000,
  parameter int CNT_W         = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_E_HIGH,
    S_HOLD,
    S_EXEC
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_HIGH_LD = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD   = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD   = CNT_W'(LONG_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             long_q;
  logic             accept;
  logic             sel_rs;
  logic [7:0]       sel_data;
  logic             sel_long;
  logic             cnt_done;

  assign lcd_rw   = 1'b0;
  assign cnt_done = (cnt == '0);

  // Ready is held off during reset so nothing is accepted while the FSM is being cleared.
  always_comb begin
    req0_ready = (state == S_IDLE) & req0_valid & ~reset;
    req1_ready = (state == S_IDLE) & req1_valid & ~req0_valid & ~reset;
    accept     = req0_ready | req1_ready;
    sel_rs     = req0_ready ? req0_rs   : req1_rs;
    sel_data   = req0_ready ? req0_data : req1_data;
    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    sel_long   = ~sel_rs & (sel_data[7:2] == 6'd0) & (sel_data[1:0] != 2'd0);
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_SETUP;
          cnt_nx   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (cnt_done) begin
          state_nx = S_E_HIGH;
          cnt_nx   = E_HIGH_LD;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      S_E_HIGH: begin
        if (cnt_done) begin
          state_nx = S_HOLD;
          cnt_nx   = HOLD_LD;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt_done) begin
          state_nx = S_EXEC;
          cnt_nx   = long_q ? LONG_LD : EXEC_LD;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      S_EXEC: begin
        if (cnt_done) begin
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      busy     <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      // E and busy are decoded from the next state so they stay glitch-free registered outputs.
      lcd_e <= (state_nx == S_E_HIGH);
      busy  <= (state_nx != S_IDLE);
      if (accept) begin
        lcd_rs   <= sel_rs;
        lcd_data <= sel_data;
        grant_id <= req1_ready;
        long_q   <= sel_long;
      end
    end
  end

endmodule
